math_alu_ctrl: RTL

MATH_ALU_CTRL -- requirements
Module: math_alu_ctrl

---
 rtl/math_alu_pkg.sv | 17 +
 rtl/math_alu_ctrl_if.sv | 25 ++
 rtl/math_adder_8bit.sv | 33 +++
 rtl/math_alu_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/math_alu_pkg.sv
// Shared opcodes and FSM encoding for the
// small add/sub/mul controller.
package math_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/math_alu_ctrl_if.sv
// Request/response bundle between a
// requester and the math ALU controller.
interface math_alu_ctrl_if;

  logic        start;
  logic [1:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic        err;

  modport master (
    output start, op, a, b,
    input  busy, done, result, carry, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, carry, err
  );

endinterface

// File: rtl/math_adder_8bit.sv
// 8-bit ripple-carry adder, the only adder
// in the ALU; shared by add, sub and mul.
module math_adder_8bit (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       ci,
  output logic [8:0] s
);

  function automatic logic [8:0] ripple(
    input logic [7:0] fx,
    input logic [7:0] fy,
    input logic       fc
  );
    logic       c;
    logic [8:0] r;
    c = fc;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i] = fx[i] ^ fy[i] ^ c;
      c    = (fx[i] & fy[i]) |
             (c & (fx[i] ^ fy[i]));
    end
    r[8] = c;
    return r;
  endfunction

  // bitwise ripple chain, carry out in s[8]
  always_comb begin
    s = ripple(x, y, ci);
  end

endmodule

// File: rtl/math_alu_ctrl.sv
// Multi-cycle add/sub/mul controller;
// mul is 8-step shift-add on the shared adder.
module math_alu_ctrl
  import math_alu_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  math_alu_ctrl_if.slave bus
);

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  a_q;
  logic [7:0]  m_q;
  logic [1:0]  op_q;
  logic [15:0] acc_q;
  logic [2:0]  cnt_q;
  logic [15:0] res_q;
  logic        carry_q;
  logic        err_q;

  logic [7:0]  add_x;
  logic [7:0]  add_y;
  logic        add_ci;
  logic [8:0]  sum;
  logic        acc_unused;

  // lsb of acc is shifted out each step
  assign acc_unused = acc_q[0];

  math_adder_8bit u_add (
    .x  (add_x),
    .y  (add_y),
    .ci (add_ci),
    .s  (sum)
  );

  // adder operand select by state/op
  always_comb begin
    add_x  = a_q;
    add_y  = m_q;
    add_ci = 1'b0;
    unique case (1'b1)
      (state_q == MUL): begin
        add_x = acc_q[15:8];
        add_y = m_q[0] ? a_q : 8'h00;
      end
      (state_q != MUL && op_q == OP_SUB): begin
        add_y  = ~m_q;
        add_ci = 1'b1;
      end
      default: ;
    endcase
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (bus.op == OP_MUL) ? MUL : EXEC;
        end
      end
      EXEC: state_d = DONE;
      MUL: begin
        if (cnt_q == 3'd7) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state, operand latch, datapath and result regs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q   <= bus.a;
            m_q   <= bus.b;
            op_q  <= bus.op;
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        EXEC: begin
          unique case (op_q)
            OP_ADD: begin
              res_q   <= {7'b0, sum};
              carry_q <= sum[8];
              err_q   <= 1'b0;
            end
            OP_SUB: begin
              res_q   <= {8'b0, sum[7:0]};
              carry_q <= ~sum[8];
              err_q   <= 1'b0;
            end
            default: begin
              res_q   <= '0;
              carry_q <= 1'b0;
              err_q   <= 1'b1;
            end
          endcase
        end
        MUL: begin
          acc_q <= {sum, acc_q[7:1]};
          m_q   <= m_q >> 1;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            res_q   <= {sum, acc_q[7:1]};
            carry_q <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = res_q;
  assign bus.carry  = carry_q;
  assign bus.err    = err_q;

endmodule
